// File: rtl/vga_fetch_pkg.sv
// Shared types and widths for the VGA framebuffer prefetch scheduler.
package vga_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CHECK,
    ST_REQ,
    ST_DONE,
    ST_DRAIN
  } fetch_state_t;

  localparam int FRAME_WORDS = 320 * 240;
  localparam int OFFSET_W    = 17;
  localparam int LEN_W       = 7;
  localparam int LEVEL_W     = 10;
  localparam int INFL_W      = 11;
  localparam int CRED_W      = 12;
  localparam int UF_CNT_W    = 16;

endpackage

// File: rtl/vga_underflow_monitor.sv
// Sticky underflow flag plus saturating event counter; a clear that lands
// together with an event leaves exactly that one event recorded.
module vga_underflow_monitor
  import vga_fetch_pkg::*;
(
  input  logic                clk_vga,
  input  logic                rst_n,
  input  logic                uf_event,
  input  logic                clear,
  output logic                sticky,
  output logic [UF_CNT_W-1:0] count
);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      sticky <= uf_event;
      count  <= uf_event ? UF_CNT_W'(1) : '0;
    end else if (uf_event) begin
      sticky <= 1'b1;
      if (count != '1)
        count <= count + UF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_frame_fetch_scheduler.sv
// Burst-read scheduler keeping the pixel FIFO ahead of the display, with
// per-frame flush/restart, double-buffer swap and credit-based flow control.
module vga_frame_fetch_scheduler
  import vga_fetch_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 22,
  parameter int BASE_A     = 0,
  parameter int BASE_B     = 131072,
  parameter int FLUSH_WAIT = 4
) (
  input  logic                clk_vga,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                frame_ready,
  input  logic [LEVEL_W-1:0]  fifo_level,
  input  logic                fifo_wr_word,
  input  logic                fifo_rd_demand,
  input  logic                fifo_empty,
  input  logic                rd_ack,
  input  logic                clear_underflow,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [LEN_W-1:0]    rd_len,
  output logic                fifo_flush,
  output logic                active_buf,
  output logic                fetch_done,
  output logic                underflow_sticky,
  output logic [UF_CNT_W-1:0] underflow_count
);

  localparam int FRAME_W = IMG_WIDTH * IMG_HEIGHT;
  localparam int WAIT_W  = (FLUSH_WAIT < 2) ? 1 : $clog2(FLUSH_WAIT + 1);

  fetch_state_t        state;
  logic [OFFSET_W-1:0] offset;
  logic [INFL_W-1:0]   inflight;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                pending_swap;
  logic                restart_pending;

  logic                restart_req;
  logic [OFFSET_W-1:0] remaining;
  logic [OFFSET_W-1:0] off_after;
  logic [LEN_W-1:0]    burst;
  logic                credit_ok;
  logic                ack_take;
  logic                word_take;
  logic [INFL_W-1:0]   inflight_next;
  logic                flush_entry;
  logic [ADDR_W-1:0]   base_addr;
  logic                uf_event;

  always_comb begin
    restart_req = restart_pending | frame_start;
    remaining   = OFFSET_W'(FRAME_W) - offset;
    off_after   = offset + OFFSET_W'(rd_len);
    burst       = (remaining > OFFSET_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(remaining);
    // Credit counts words already in the FIFO plus words requested but not yet written.
    credit_ok   = (CRED_W'(fifo_level) + CRED_W'(inflight) + CRED_W'(burst)) <= CRED_W'(FIFO_DEPTH);
    ack_take    = rd_req & rd_ack;
    word_take   = fifo_wr_word & ((inflight != '0) | ack_take);
    inflight_next = inflight + (ack_take ? INFL_W'(rd_len) : '0) - (word_take ? INFL_W'(1) : '0);
    // IDLE restarts immediately; DRAIN restarts once every requested word has landed.
    flush_entry = ((state == ST_IDLE) && restart_req) || ((state == ST_DRAIN) && (inflight == '0));
    base_addr   = active_buf ? ADDR_W'(BASE_B) : ADDR_W'(BASE_A);
    uf_event    = fifo_rd_demand & fifo_empty & (state != ST_FLUSH) & (state != ST_DRAIN);
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      offset          <= '0;
      inflight        <= '0;
      wait_cnt        <= '0;
      pending_swap    <= 1'b0;
      restart_pending <= 1'b0;
      rd_req          <= 1'b0;
      rd_addr         <= '0;
      rd_len          <= '0;
      fifo_flush      <= 1'b0;
      active_buf      <= 1'b0;
      fetch_done      <= 1'b0;
    end else begin
      inflight   <= inflight_next;
      fifo_flush <= 1'b0;
      if (frame_ready)
        pending_swap <= 1'b1;
      if (frame_start)
        restart_pending <= 1'b1;

      if (flush_entry) begin
        state           <= ST_FLUSH;
        fifo_flush      <= 1'b1;
        offset          <= '0;
        wait_cnt        <= '0;
        restart_pending <= 1'b0;
        fetch_done      <= 1'b0;
        // A frame_ready arriving on this very cycle stays queued for the next frame.
        if (pending_swap) begin
          active_buf   <= ~active_buf;
          pending_swap <= frame_ready;
        end
      end else begin
        case (state)
          ST_FLUSH: begin
            if (wait_cnt == WAIT_W'(FLUSH_WAIT))
              state <= ST_CHECK;
            else
              wait_cnt <= wait_cnt + WAIT_W'(1);
          end
          ST_CHECK: begin
            if (restart_req) begin
              state <= ST_DRAIN;
            end else if (credit_ok) begin
              rd_req  <= 1'b1;
              rd_addr <= base_addr + ADDR_W'(offset);
              rd_len  <= burst;
              state   <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (rd_ack) begin
              rd_req <= 1'b0;
              offset <= off_after;
              if (restart_req) begin
                state <= ST_DRAIN;
              end else if (off_after == OFFSET_W'(FRAME_W)) begin
                state      <= ST_DONE;
                fetch_done <= 1'b1;
              end else begin
                state <= ST_CHECK;
              end
            end
          end
          ST_DONE: begin
            if (restart_req)
              state <= ST_DRAIN;
          end
          default: ;
        endcase
      end
    end
  end

  vga_underflow_monitor u_underflow (
    .clk_vga  (clk_vga),
    .rst_n    (rst_n),
    .uf_event (uf_event),
    .clear    (clear_underflow),
    .sticky   (underflow_sticky),
    .count    (underflow_count)
  );

endmodule
